// File: rtl/multdiv_arb_pkg.sv
// Shared encodings for the multdiv request arbiter: op codes, FSM states and
// nominal multdiv latencies.
package multdiv_arb_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Nominal multdiv latencies after the ctrl pulse; the arbiter never relies on them.
    localparam int MULT_LATENCY = 16;
    localparam int DIV_LATENCY  = 32;

endpackage

// File: rtl/multdiv_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins, and on a tie the
// requester that did not win last time is chosen.
module multdiv_rr_pick (
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    assign grant_valid = req0_valid | req1_valid;
    assign grant       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

endmodule

// File: rtl/multdiv_arbiter.sv
// Round-robin arbiter/sequencer sharing one multdiv unit between two requesters.
// Optional watchdog abort in WAIT is enabled by defining MULTDIV_ARB_TIMEOUT_EN.
module multdiv_arbiter
    import multdiv_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic        req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    input  logic        req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp_result,
    output logic        resp_exception,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_result_rdy,
    output logic        busy
);

    state_t      state, state_nxt;
    logic        grant, grant_valid, handshake;
    logic        last_grant, owner, op_q, timeout;
    logic [31:0] a_q, b_q, res_q;
    logic        exc_q;

    multdiv_rr_pick u_pick (
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign req0_ready = (state == IDLE) && grant_valid && !grant;
    assign req1_ready = (state == IDLE) && grant_valid &&  grant;
    assign handshake  = req0_ready | req1_ready;

`ifdef MULTDIV_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] wd_cnt;

    // Last WAIT cycle is count TIMEOUT_CYCLES-1, so RESP lands TIMEOUT_CYCLES after WAIT entry.
    assign timeout = (state == WAIT) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)             wd_cnt <= '0;
        else if (state == ISSUE)  wd_cnt <= '0;
        else if (state == WAIT)   wd_cnt <= wd_cnt + 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(TIMEOUT_CYCLES), 32'(CNT_W)};
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (handshake) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (md_result_rdy || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= OP_MULT;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            exc_q      <= 1'b0;
        end else begin
            if (handshake) begin
                last_grant <= grant;
                owner      <= grant;
                op_q       <= grant ? req1_op : req0_op;
                a_q        <= grant ? req1_a  : req0_a;
                b_q        <= grant ? req1_b  : req0_b;
            end
            // Strobes outside WAIT are stale completions and must not touch the response.
            if (state == WAIT) begin
                if (md_result_rdy) begin
                    res_q <= md_result;
                    exc_q <= md_exception;
                end else if (timeout) begin
                    res_q <= '0;
                    exc_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        busy         = (state != IDLE);
        if (state == ISSUE) begin
            md_ctrl_mult = (op_q == OP_MULT);
            md_ctrl_div  = (op_q == OP_DIV);
        end
        if (state == RESP) begin
            resp0_valid = !owner;
            resp1_valid = owner;
        end
    end

    assign md_operand_a   = a_q;
    assign md_operand_b   = b_q;
    assign resp_result    = res_q;
    assign resp_exception = exc_q;

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Directed bench for multdiv_arbiter with a behavioural multdiv stub.
// Build with MULTDIV_ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_multdiv_arbiter;
    import multdiv_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 0, req0_op = 0, req1_valid = 0, req1_op = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp_result, md_operand_a, md_operand_b;
    logic        resp_exception, md_ctrl_mult, md_ctrl_div, busy;
    logic [31:0] md_result = 0;
    logic        md_exception = 0, md_result_rdy = 0;

    int errors = 0, checks = 0;
    int n_mult = 0, n_div = 0, n_resp0 = 0, n_resp1 = 0, n_both_ready = 0;
    bit md_stall = 0, spur = 0;
    int md_left = 0;

    always #5 clock = ~clock;

    multdiv_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_result(resp_result), .resp_exception(resp_exception),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
        .md_result(md_result), .md_exception(md_exception), .md_result_rdy(md_result_rdy),
        .busy(busy)
    );

    // Multdiv stub: restarts on every pulse, never reset, strobes ready once at the end.
    always @(posedge clock) begin
        longint p;
        md_result_rdy <= spur;
        if (md_ctrl_mult) begin
            p = longint'($signed(md_operand_a)) * longint'($signed(md_operand_b));
            md_result    <= p[31:0];
            md_exception <= (p != longint'($signed(p[31:0])));
            md_left      <= MULT_LATENCY;
        end else if (md_ctrl_div) begin
            if (md_operand_b == 0) begin
                md_result    <= 32'd0;
                md_exception <= 1'b1;
            end else begin
                md_result    <= $signed(md_operand_a) / $signed(md_operand_b);
                md_exception <= 1'b0;
            end
            md_left <= DIV_LATENCY;
        end else if (md_left != 0) begin
            md_left <= md_left - 1;
            if (md_left == 1 && !md_stall) md_result_rdy <= 1'b1;
        end
    end

    always @(negedge clock) begin
        n_mult       += int'(md_ctrl_mult);
        n_div        += int'(md_ctrl_div);
        n_resp0      += int'(resp0_valid);
        n_resp1      += int'(resp1_valid);
        n_both_ready += int'(req0_ready && req1_ready);
    end

    task automatic do_req(input bit who, input bit op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit exp_exc, input string name);
        bit got, prev;
        @(posedge clock); #1;
        if (!who) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        else      begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (who ? req1_ready : req0_ready) begin got = 1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL %s_ready: got no ready, required ready within 20 cycles", name); end
        @(posedge clock); #1;
        req0_valid = 0; req1_valid = 0;
        got = 0; prev = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (resp0_valid || resp1_valid) begin got = 1; break; end
            prev = md_result_rdy;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL %s_resp: no response within 100 cycles", name); end
        checks++;
        if (resp1_valid !== who || resp0_valid !== !who) begin
            errors++; $display("FAIL %s_owner: resp0=%b resp1=%b, required owner %0d", name, resp0_valid, resp1_valid, who);
        end
        checks++;
        if (prev !== 1'b1) begin errors++; $display("FAIL %s_latency: md_result_rdy previous cycle=%b, required 1", name, prev); end
        checks++;
        if (resp_result !== exp_res) begin errors++; $display("FAIL %s_result: got %h, required %h", name, resp_result, exp_res); end
        checks++;
        if (resp_exception !== exp_exc) begin errors++; $display("FAIL %s_exception: got %b, required %b", name, resp_exception, exp_exc); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, req0_ready, req1_ready, resp0_valid, resp1_valid, md_ctrl_mult, md_ctrl_div, resp_exception} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: got %b, required 00000000",
                {busy, req0_ready, req1_ready, resp0_valid, resp1_valid, md_ctrl_mult, md_ctrl_div, resp_exception});
        end
        checks++;
        if ({md_operand_a, md_operand_b, resp_result} !== 96'd0) begin
            errors++; $display("FAIL reset_data: a=%h b=%h res=%h, required all zero", md_operand_a, md_operand_b, resp_result);
        end
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
    endtask

    task automatic test_arbitration;
        bit order[4];
        bit exp_order[4];
        int n, both0;
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        both0 = n_both_ready;
        n = 0;
        @(posedge clock); #1;
        req0_valid = 1; req0_op = OP_MULT; req0_a = 2; req0_b = 3;
        req1_valid = 1; req1_op = OP_MULT; req1_a = 5; req1_b = 5;
        for (int k = 0; k < 400 && n < 4; k++) begin
            @(negedge clock);
            if (req0_ready)      begin order[n] = 1'b0; n++; end
            else if (req1_ready) begin order[n] = 1'b1; n++; end
        end
        @(posedge clock); #1;
        req0_valid = 0; req1_valid = 0;
        checks++;
        if (n != 4) begin errors++; $display("FAIL arb_count: got %0d grants, required 4", n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] !== exp_order[i]) begin
                errors++; $display("FAIL arb_order[%0d]: got %0d, required %0d", i, order[i], exp_order[i]);
            end
        end
        for (int k = 0; k < 100 && busy; k++) @(negedge clock);
        checks++;
        if (n_both_ready != both0) begin errors++; $display("FAIL arb_both_ready: got %0d cycles, required 0", n_both_ready - both0); end
    endtask

    task automatic test_mult;
        int m0 = n_mult, d0 = n_div, r0 = n_resp0, r1 = n_resp1;
        do_req(1'b0, OP_MULT, 32'd7, 32'd6, 32'd42, 1'b0, "mult");
        checks++;
        if (n_mult - m0 != 1 || n_div != d0) begin
            errors++; $display("FAIL mult_pulse: mult=%0d div=%0d, required 1 and 0", n_mult - m0, n_div - d0);
        end
        checks++;
        if (n_resp0 - r0 != 1 || n_resp1 != r1) begin
            errors++; $display("FAIL mult_strobes: resp0=%0d resp1=%0d, required 1 and 0", n_resp0 - r0, n_resp1 - r1);
        end
    endtask

    task automatic test_div;
        int d0 = n_div;
        do_req(1'b1, OP_DIV, -32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0, "div_signed");
        do_req(1'b1, OP_DIV, 32'd5, 32'd0, 32'd0, 1'b1, "div_zero");
        checks++;
        if (n_div - d0 != 2) begin errors++; $display("FAIL div_pulse: got %0d, required 2", n_div - d0); end
    endtask

    task automatic test_spurious;
        int r = n_resp0 + n_resp1, idle_bad = 0;
        @(posedge clock); #1 spur = 1;
        @(posedge clock); #1 spur = 0;
        repeat (4) begin @(negedge clock); if (busy !== 1'b0) idle_bad++; end
        checks++;
        if (idle_bad != 0) begin errors++; $display("FAIL spur_idle: busy seen %0d cycles, required 0", idle_bad); end
        checks++;
        if (n_resp0 + n_resp1 != r) begin errors++; $display("FAIL spur_resp: got %0d strobes, required 0", n_resp0 + n_resp1 - r); end
    endtask

    task automatic test_reset_mid_op;
        int r, busy_bad = 0;
        @(posedge clock); #1;
        req0_valid = 1; req0_op = OP_MULT; req0_a = 9; req0_b = 9;
        @(negedge clock);
        @(posedge clock); #1 req0_valid = 0;
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: busy=%b, required 1", busy); end
        r = n_resp0 + n_resp1;
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        reset_n = 1;
        repeat (20) begin @(negedge clock); if (busy !== 1'b0) busy_bad++; end
        checks++;
        if (busy_bad != 0) begin errors++; $display("FAIL midrst_idle: busy %0d cycles, required 0", busy_bad); end
        checks++;
        if (n_resp0 + n_resp1 != r) begin errors++; $display("FAIL midrst_resp: got %0d strobes, required 0", n_resp0 + n_resp1 - r); end
        do_req(1'b0, OP_MULT, 32'd3, 32'd4, 32'd12, 1'b0, "midrst_next");
    endtask

    task automatic test_timeout;
        md_stall = 1;
        @(posedge clock); #1;
        req1_valid = 1; req1_op = OP_DIV; req1_a = 8; req1_b = 2;
        @(negedge clock);
        @(posedge clock); #1 req1_valid = 0;
`ifdef MULTDIV_ARB_TIMEOUT_EN
        begin
            int n = 100;
            for (int k = 0; k < 100; k++) begin
                @(negedge clock);
                if (resp1_valid) begin n = k; break; end
            end
            // k=0 is ISSUE, k=1 is first WAIT cycle: response lands 40 cycles later.
            checks++;
            if (n != 41) begin errors++; $display("FAIL timeout_cycle: got %0d, required 41", n); end
            checks++;
            if (resp_result !== 32'd0 || resp_exception !== 1'b1) begin
                errors++; $display("FAIL timeout_resp: res=%h exc=%b, required 0 and 1", resp_result, resp_exception);
            end
            @(posedge clock); #1;
        end
`else
        begin
            int idle = 0;
            repeat (200) begin @(negedge clock); if (busy !== 1'b1) idle++; end
            checks++;
            if (idle != 0) begin errors++; $display("FAIL no_timeout_busy: idle %0d cycles, required 0", idle); end
            checks++;
            if (n_resp1 != 4) begin errors++; $display("FAIL no_timeout_resp: resp1 total %0d, required 4", n_resp1); end
            @(posedge clock); #1 reset_n = 0;
            @(posedge clock); #1 reset_n = 1;
        end
`endif
        md_stall = 0;
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_mult();
        test_div();
        test_spurious();
        test_reset_mid_op();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
